// File: rtl/reg_file_if.sv
// Register file port bundle: one write port and two read ports.
// The master drives the write port and read addresses. The slave (the
// register file) returns the registered read data and valid flags.
interface reg_file_if #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 3
);
    logic              clr;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [WIDTH-1:0]  wr_data;
    logic [ADDR_W-1:0] rd_addr_a;
    logic [WIDTH-1:0]  rd_data_a;
    logic              rd_valid_a;
    logic [ADDR_W-1:0] rd_addr_b;
    logic [WIDTH-1:0]  rd_data_b;
    logic              rd_valid_b;

    modport master (
        output clr, wr_en, wr_addr, wr_data, rd_addr_a, rd_addr_b,
        input  rd_data_a, rd_valid_a, rd_data_b, rd_valid_b
    );

    modport slave (
        input  clr, wr_en, wr_addr, wr_data, rd_addr_a, rd_addr_b,
        output rd_data_a, rd_valid_a, rd_data_b, rd_valid_b
    );
endinterface

// File: rtl/reg_file.sv
// General-purpose register file: DEPTH words of WIDTH bits. Each word has a
// valid flag. There is one write port and two independent read ports with
// registered outputs, plus a single-cycle clear. When BYPASS=1, a read returns
// the array state after the same edge's clear/write. When BYPASS=0, it returns
// the state before that edge.
module reg_file #(
    parameter int WIDTH  = 16,
    parameter int DEPTH  = 8,
    parameter int BYPASS = 1,
    localparam int ADDR_W = (DEPTH > 2) ? $clog2(DEPTH) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    reg_file_if.slave       bus
);
    // DEPTH always fits in ADDR_W+1 bits, so range checks stay width-exact.
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [0:DEPTH-1];
    logic [DEPTH-1:0] vld;
    logic             wr_ok;
    logic [WIDTH:0]   next_a;
    logic [WIDTH:0]   next_b;

    function automatic logic in_range(input logic [ADDR_W-1:0] addr);
        return ({1'b0, addr} < DEPTH_L);
    endfunction

    // Returns {valid, data} that a read of addr should capture at this edge.
    function automatic logic [WIDTH:0] read_word(
        input logic [ADDR_W-1:0] addr,
        input logic              wr_hit,
        input logic [ADDR_W-1:0] waddr,
        input logic [WIDTH-1:0]  wdata,
        input logic              clr_now
    );
        logic [WIDTH:0] r;
        r = '0;
        if (in_range(addr)) begin
            if (BYPASS != 0 && wr_hit && waddr == addr)
                r = {1'b1, wdata};
            else if (BYPASS != 0 && clr_now)
                r = '0;
            else
                r = {vld[addr], mem[addr]};
        end
        return r;
    endfunction

    // Writes to out-of-range addresses are dropped entirely.
    assign wr_ok = bus.wr_en && in_range(bus.wr_addr);

    // Next read values for both ports, with the bypass rule applied.
    always_comb begin
        next_a = read_word(bus.rd_addr_a, wr_ok, bus.wr_addr, bus.wr_data, bus.clr);
        next_b = read_word(bus.rd_addr_b, wr_ok, bus.wr_addr, bus.wr_data, bus.clr);
    end

    // Array update: clear first, then any write, so a write during a clear survives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            vld <= '0;
        end else begin
            if (bus.clr) begin
                for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
                vld <= '0;
            end
            if (wr_ok) begin
                mem[bus.wr_addr] <= bus.wr_data;
                vld[bus.wr_addr] <= 1'b1;
            end
        end
    end

    // Registered read ports.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.rd_data_a  <= '0;
            bus.rd_valid_a <= 1'b0;
            bus.rd_data_b  <= '0;
            bus.rd_valid_b <= 1'b0;
        end else begin
            bus.rd_data_a  <= next_a[WIDTH-1:0];
            bus.rd_valid_a <= next_a[WIDTH];
            bus.rd_data_b  <= next_b[WIDTH-1:0];
            bus.rd_valid_b <= next_b[WIDTH];
        end
    end
endmodule

// File: tb/tb_reg_file.sv
// Directed testbench: a BYPASS=1 and a BYPASS=0 instance (DEPTH=8) get
// identical stimulus. A DEPTH=6 instance covers out-of-range addresses.
module tb_reg_file;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   passed = 0;

    always #5 clk = ~clk;

    reg_file_if #(.WIDTH(16), .ADDR_W(3)) b1 ();
    reg_file_if #(.WIDTH(16), .ADDR_W(3)) b0 ();
    reg_file_if #(.WIDTH(16), .ADDR_W(3)) b6 ();

    reg_file #(.WIDTH(16), .DEPTH(8), .BYPASS(1)) dut_byp  (.clk(clk), .rst_n(rst_n), .bus(b1));
    reg_file #(.WIDTH(16), .DEPTH(8), .BYPASS(0)) dut_nbyp (.clk(clk), .rst_n(rst_n), .bus(b0));
    reg_file #(.WIDTH(16), .DEPTH(6), .BYPASS(1)) dut_d6   (.clk(clk), .rst_n(rst_n), .bus(b6));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Same stimulus to both DEPTH=8 instances.
    task automatic drv(input logic c, input logic we, input logic [2:0] wa,
                       input logic [15:0] wd, input logic [2:0] ra, input logic [2:0] rb);
        b1.clr = c; b1.wr_en = we; b1.wr_addr = wa; b1.wr_data = wd;
        b1.rd_addr_a = ra; b1.rd_addr_b = rb;
        b0.clr = c; b0.wr_en = we; b0.wr_addr = wa; b0.wr_data = wd;
        b0.rd_addr_a = ra; b0.rd_addr_b = rb;
    endtask

    task automatic drv6(input logic we, input logic [2:0] wa, input logic [15:0] wd,
                        input logic [2:0] ra, input logic [2:0] rb);
        b6.clr = 1'b0; b6.wr_en = we; b6.wr_addr = wa; b6.wr_data = wd;
        b6.rd_addr_a = ra; b6.rd_addr_b = rb;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset held while a write is attempted.
        drv(1'b0, 1'b1, 3'd3, 16'h5555, 3'd3, 3'd3);
        drv6(1'b1, 3'd3, 16'h5555, 3'd3, 3'd3);
        tick();
        tick();
        check("rst_byp_da", b1.rd_data_a, 0);
        check("rst_byp_va", b1.rd_valid_a, 0);
        check("rst_byp_db", b1.rd_data_b, 0);
        check("rst_byp_vb", b1.rd_valid_b, 0);
        check("rst_nbyp_da", b0.rd_data_a, 0);
        check("rst_nbyp_va", b0.rd_valid_a, 0);

        // Release reset; the write attempted during reset must be lost.
        rst_n = 1'b1;
        drv(1'b0, 1'b0, 3'd0, 16'h0, 3'd3, 3'd3);
        drv6(1'b0, 3'd0, 16'h0, 3'd0, 3'd0);
        tick();
        check("rel_byp_da", b1.rd_data_a, 0);
        check("rel_byp_vb", b1.rd_valid_b, 0);
        check("rel_nbyp_db", b0.rd_data_b, 0);
        check("rel_nbyp_va", b0.rd_valid_a, 0);

        // Write, then read from two ports.
        drv(1'b0, 1'b1, 3'd2, 16'h1234, 3'd0, 3'd0);
        tick();
        drv(1'b0, 1'b0, 3'd0, 16'h0, 3'd2, 3'd5);
        tick();
        check("wr_byp_da", b1.rd_data_a, 16'h1234);
        check("wr_byp_va", b1.rd_valid_a, 1);
        check("wr_byp_db", b1.rd_data_b, 0);
        check("wr_byp_vb", b1.rd_valid_b, 0);
        check("wr_nbyp_da", b0.rd_data_a, 16'h1234);
        check("wr_nbyp_vb", b0.rd_valid_b, 0);

        // Same-edge write and read of address 4.
        drv(1'b0, 1'b1, 3'd4, 16'hBEEF, 3'd4, 3'd2);
        tick();
        check("byp_same_da", b1.rd_data_a, 16'hBEEF);
        check("byp_same_va", b1.rd_valid_a, 1);
        check("nbyp_same_da", b0.rd_data_a, 0);
        check("nbyp_same_va", b0.rd_valid_a, 0);
        check("nbyp_same_db", b0.rd_data_b, 16'h1234);
        drv(1'b0, 1'b0, 3'd0, 16'h0, 3'd4, 3'd4);
        tick();
        check("nbyp_next_da", b0.rd_data_a, 16'hBEEF);
        check("nbyp_next_va", b0.rd_valid_a, 1);
        check("byp_next_db", b1.rd_data_b, 16'hBEEF);

        // Fill every word, then clear together with a write to address 1.
        for (int i = 0; i < 8; i++) begin
            drv(1'b0, 1'b1, 3'(i), 16'h1000 + 16'(i), 3'd0, 3'd0);
            tick();
        end
        drv(1'b1, 1'b1, 3'd1, 16'h00FF, 3'd1, 3'd0);
        tick();
        check("clrw_byp_da", b1.rd_data_a, 16'h00FF);
        check("clrw_byp_va", b1.rd_valid_a, 1);
        check("clrw_byp_db", b1.rd_data_b, 0);
        check("clrw_byp_vb", b1.rd_valid_b, 0);
        check("clrw_nbyp_da", b0.rd_data_a, 16'h1001);
        check("clrw_nbyp_db", b0.rd_data_b, 16'h1000);
        for (int i = 0; i < 8; i++) begin
            drv(1'b0, 1'b0, 3'd0, 16'h0, 3'(i), 3'(i));
            tick();
            check($sformatf("clr_byp_d%0d", i), b1.rd_data_a, (i == 1) ? 16'h00FF : 16'h0);
            check($sformatf("clr_byp_v%0d", i), b1.rd_valid_a, (i == 1) ? 1 : 0);
            check($sformatf("clr_nbyp_d%0d", i), b0.rd_data_b, (i == 1) ? 16'h00FF : 16'h0);
            check($sformatf("clr_nbyp_v%0d", i), b0.rd_valid_b, (i == 1) ? 1 : 0);
        end

        // DEPTH=6 instance: out-of-range write and read.
        drv6(1'b1, 3'd5, 16'h1111, 3'd0, 3'd0);
        tick();
        drv6(1'b1, 3'd6, 16'hAAAA, 3'd6, 3'd5);
        tick();
        check("oor_byp_d6", b6.rd_data_a, 0);
        check("oor_byp_v6", b6.rd_valid_a, 0);
        check("oor_d5", b6.rd_data_b, 16'h1111);
        drv6(1'b0, 3'd0, 16'h0, 3'd7, 3'd6);
        tick();
        check("oor_rd7_d", b6.rd_data_a, 0);
        check("oor_rd7_v", b6.rd_valid_a, 0);
        check("oor_rd6_v", b6.rd_valid_b, 0);
        for (int i = 0; i < 6; i++) begin
            drv6(1'b0, 3'd0, 16'h0, 3'(i), 3'(i));
            tick();
            check($sformatf("oor_scan_d%0d", i), b6.rd_data_a, (i == 5) ? 16'h1111 : 16'h0);
            check($sformatf("oor_scan_v%0d", i), b6.rd_valid_b, (i == 5) ? 1 : 0);
        end

        // Asynchronous reset between edges.
        drv(1'b0, 1'b0, 3'd0, 16'h0, 3'd1, 3'd1);
        drv6(1'b0, 3'd0, 16'h0, 3'd5, 3'd5);
        tick();
        check("pre_arst_va", b1.rd_valid_a, 1);
        check("pre_arst_d6", b6.rd_data_a, 16'h1111);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_byp_da", b1.rd_data_a, 0);
        check("arst_byp_va", b1.rd_valid_a, 0);
        check("arst_nbyp_db", b0.rd_data_b, 0);
        check("arst_d6_da", b6.rd_data_a, 0);
        check("arst_d6_vb", b6.rd_valid_b, 0);
        tick();
        rst_n = 1'b1;
        tick();
        check("post_arst_byp_d", b1.rd_data_a, 0);
        check("post_arst_byp_v", b1.rd_valid_a, 0);
        check("post_arst_nbyp_v", b0.rd_valid_b, 0);
        check("post_arst_d6_d", b6.rd_data_a, 0);
        check("post_arst_d6_v", b6.rd_valid_a, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
